// File: rtl/latency_stats_pkg.sv
// Shared types for the latency statistics block: table record layout,
// the producer's result word and the controller states.
package latency_stats_pkg;

    typedef struct packed {
        logic [31:0] count;
        logic [47:0] sum;
        logic [31:0] min;
        logic [31:0] max;
    } stats_entry_t;

    // tag = {reserved, index}; only the low INDEX_WIDTH bits carry the index
    typedef struct packed {
        logic [15:0] tag;
        logic [31:0] latency;
    } result_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_UPD_RD,
        ST_UPD_WR,
        ST_QRY_RD,
        ST_QRY_OUT
    } state_t;

    localparam int unsigned ENTRY_W = $bits(stats_entry_t);

    localparam stats_entry_t ENTRY_EMPTY = '{
        count: 32'd0,
        sum:   48'd0,
        min:   32'hFFFF_FFFF,
        max:   32'd0
    };

endpackage

// File: rtl/latency_stats_update.sv
// Folds one latency sample into a statistics record: saturating count
// and sum, unsigned running min/max.
module latency_stats_update
    import latency_stats_pkg::*;
(
    input  stats_entry_t entry_i,
    input  logic [31:0]  latency_i,
    output stats_entry_t entry_o
);

    logic [48:0] sum_wide;

    always_comb begin
        sum_wide      = {1'b0, entry_i.sum} + {17'd0, latency_i};
        entry_o       = entry_i;
        entry_o.count = (entry_i.count == 32'hFFFF_FFFF) ? entry_i.count : entry_i.count + 32'd1;
        entry_o.sum   = sum_wide[48] ? 48'hFFFF_FFFF_FFFF : sum_wide[47:0];
        entry_o.min   = (latency_i < entry_i.min) ? latency_i : entry_i.min;
        entry_o.max   = (latency_i > entry_i.max) ? latency_i : entry_i.max;
    end

endmodule

// File: rtl/ram_fifo.sv
// Small show-ahead FIFO; the head word is readable before pop.
// A push at full is accepted only if a pop frees a slot in the same cycle.
module ram_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             drop
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full, do_push, do_pop;

    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == FULL_CNT);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        drop     = push && !do_push;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    assign pop_data = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data holds its value until the next read enable.
module ram_sdp #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/latency_stats.sv
// Per-index latency statistics table fed by the measurement core's result
// stream, with a request/acknowledge query port and optional clear-on-read.
module latency_stats
    import latency_stats_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 9,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   latency_valid,
    input  logic [47:0]            latency_data,
    output logic                   init_done,
    input  logic                   qry_req,
    output logic                   qry_ready,
    input  logic [INDEX_WIDTH-1:0] qry_index,
    input  logic                   qry_clear,
    output logic                   qry_valid,
    output logic [31:0]            qry_count,
    output logic [47:0]            qry_sum,
    output logic [31:0]            qry_min,
    output logic [31:0]            qry_max,
    output logic                   err_fifo_ovfl
);

    localparam int unsigned NUM_ENTRIES = 1 << INDEX_WIDTH;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]            lat_q, lat_d;
    logic                   clr_q, clr_d;
    logic                   init_done_q, init_done_d;
    logic                   qry_valid_q, qry_valid_d;
    stats_entry_t           qry_data_q, qry_data_d;
    logic                   ovfl_q;

    result_t                fifo_dout;
    logic                   fifo_pop, fifo_empty, fifo_drop;
    logic                   unused_rsvd;

    logic                   ram_we, ram_re;
    logic [INDEX_WIDTH-1:0] ram_raddr;
    stats_entry_t           ram_wdata, ram_rd, upd_entry;

    ram_fifo #(.WIDTH($bits(result_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (latency_valid),
        .push_data (latency_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    // addr_q doubles as sweep address during init and as the latched
    // record index for updates and queries, so it is also the write address.
    ram_sdp #(.WIDTH(ENTRY_W), .DEPTH(NUM_ENTRIES)) u_table (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (addr_q),
        .wr_data (ram_wdata),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_rd)
    );

    latency_stats_update u_update (
        .entry_i   (ram_rd),
        .latency_i (lat_q),
        .entry_o   (upd_entry)
    );

    assign unused_rsvd = ^fifo_dout.tag;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lat_d       = lat_q;
        clr_d       = clr_q;
        init_done_d = init_done_q | (state_q != ST_INIT);
        qry_valid_d = 1'b0;
        qry_data_d  = qry_data_q;
        qry_ready   = 1'b0;
        fifo_pop    = 1'b0;
        ram_we      = 1'b0;
        ram_wdata   = ENTRY_EMPTY;
        ram_re      = 1'b0;
        ram_raddr   = addr_q;
        case (state_q)
            ST_INIT: begin
                ram_we = 1'b1;
                addr_d = addr_q + 1'b1;
                if (addr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                qry_ready = fifo_empty;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    addr_d    = fifo_dout.tag[INDEX_WIDTH-1:0];
                    lat_d     = fifo_dout.latency;
                    ram_re    = 1'b1;
                    ram_raddr = fifo_dout.tag[INDEX_WIDTH-1:0];
                    state_d   = ST_UPD_RD;
                end else if (qry_req) begin
                    addr_d    = qry_index;
                    clr_d     = qry_clear;
                    ram_re    = 1'b1;
                    ram_raddr = qry_index;
                    state_d   = ST_QRY_RD;
                end
            end
            ST_UPD_RD: state_d = ST_UPD_WR;
            ST_UPD_WR: begin
                ram_we    = 1'b1;
                ram_wdata = upd_entry;
                state_d   = ST_IDLE;
            end
            ST_QRY_RD: state_d = ST_QRY_OUT;
            ST_QRY_OUT: begin
                qry_valid_d = 1'b1;
                qry_data_d  = ram_rd;
                ram_we      = clr_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            addr_q      <= '0;
            lat_q       <= '0;
            clr_q       <= 1'b0;
            init_done_q <= 1'b0;
            qry_valid_q <= 1'b0;
            qry_data_q  <= '0;
            ovfl_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lat_q       <= lat_d;
            clr_q       <= clr_d;
            init_done_q <= init_done_d;
            qry_valid_q <= qry_valid_d;
            qry_data_q  <= qry_data_d;
            ovfl_q      <= fifo_drop;
        end
    end

    assign init_done     = init_done_q;
    assign qry_valid     = qry_valid_q;
    assign qry_count     = qry_data_q.count;
    assign qry_sum       = qry_data_q.sum;
    assign qry_min       = qry_data_q.min;
    assign qry_max       = qry_data_q.max;
    assign err_fifo_ovfl = ovfl_q;

endmodule

// File: tb/tb_latency_stats.sv
// Self-checking bench for latency_stats: reference record model, expected
// response queue popped on qry_valid, and a standalone update-function check.
module tb_latency_stats;
    import latency_stats_pkg::*;

    localparam int IW = 9;
    localparam int N  = 1 << IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          latency_valid = 1'b0;
    logic [47:0]   latency_data = '0;
    logic          init_done;
    logic          qry_req = 1'b0;
    logic          qry_ready;
    logic [IW-1:0] qry_index = '0;
    logic          qry_clear = 1'b0;
    logic          qry_valid;
    logic [31:0]   qry_count;
    logic [47:0]   qry_sum;
    logic [31:0]   qry_min;
    logic [31:0]   qry_max;
    logic          err_fifo_ovfl;

    stats_entry_t  sat_in, sat_out, sat_exp;
    logic [31:0]   sat_lat;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_resp = 0;
    int            n_ovfl = 0;
    logic [143:0]  exp_q[$];
    logic [143:0]  exp_rec;
    stats_entry_t  model [N];

    always #5 clk = ~clk;

    latency_stats #(.INDEX_WIDTH(IW), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .latency_valid (latency_valid),
        .latency_data  (latency_data),
        .init_done     (init_done),
        .qry_req       (qry_req),
        .qry_ready     (qry_ready),
        .qry_index     (qry_index),
        .qry_clear     (qry_clear),
        .qry_valid     (qry_valid),
        .qry_count     (qry_count),
        .qry_sum       (qry_sum),
        .qry_min       (qry_min),
        .qry_max       (qry_max),
        .err_fifo_ovfl (err_fifo_ovfl)
    );

    latency_stats_update u_ref_upd (
        .entry_i   (sat_in),
        .latency_i (sat_lat),
        .entry_o   (sat_out)
    );

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic stats_entry_t model_upd(input stats_entry_t e, input logic [31:0] lat);
        stats_entry_t r;
        logic [48:0]  s;
        r       = e;
        s       = {1'b0, e.sum} + {17'd0, lat};
        r.count = (e.count == 32'hFFFF_FFFF) ? e.count : e.count + 32'd1;
        r.sum   = s[48] ? 48'hFFFF_FFFF_FFFF : s[47:0];
        r.min   = (lat < e.min) ? lat : e.min;
        r.max   = (lat > e.max) ? lat : e.max;
        return r;
    endfunction

    // scoreboard: every response must match the oldest expected record
    always @(negedge clk) begin
        if (qry_valid) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                check("unexpected_qry_valid", 144'd1, 144'd0);
            end else begin
                exp_rec = exp_q.pop_front();
                check("qry_record", {qry_count, qry_sum, qry_min, qry_max}, exp_rec);
            end
        end
        if (err_fifo_ovfl) n_ovfl++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int idx, input logic [31:0] lat, input bit accepted);
        logic [IW-1:0] ix;
        ix            = idx[IW-1:0];
        latency_valid = 1'b1;
        latency_data  = {7'($urandom_range(0, 127)), ix, lat};
        if (accepted) model[idx] = model_upd(model[idx], lat);
        tick(1);
        latency_valid = 1'b0;
    endtask

    task automatic send_spaced(input int idx, input logic [31:0] lat);
        send(idx, lat, 1'b1);
        tick(5);
    endtask

    task automatic query(input int idx, input bit clr);
        int waitc;
        int lat;
        qry_req   = 1'b1;
        qry_index = idx[IW-1:0];
        qry_clear = clr;
        waitc     = 0;
        while (!qry_ready && waitc < 200) begin
            tick(1);
            waitc++;
        end
        if (!qry_ready) begin
            check("qry_accept_timeout", 144'd0, 144'd1);
            qry_req = 1'b0;
            return;
        end
        exp_q.push_back(model[idx]);
        if (clr) model[idx] = ENTRY_EMPTY;
        tick(1);
        qry_req = 1'b0;
        lat     = 1;
        while (!qry_valid && lat < 20) begin
            tick(1);
            lat++;
        end
        check("qry_latency", 144'(lat), 144'd3);
        tick(1);
    endtask

    task automatic reset_and_init(input string tag);
        int n;
        rst           = 1'b1;
        latency_valid = 1'b0;
        qry_req       = 1'b0;
        tick(2);
        check("rst_init_done", 144'(init_done), 144'd0);
        check("rst_qry_valid", 144'(qry_valid), 144'd0);
        check("rst_qry_ready", 144'(qry_ready), 144'd0);
        check("rst_ovfl", 144'(err_fifo_ovfl), 144'd0);
        check("rst_qry_data", {qry_count, qry_sum, qry_min, qry_max}, 144'd0);
        for (int i = 0; i < N; i++) model[i] = ENTRY_EMPTY;
        rst = 1'b0;
        n   = 0;
        while (!init_done && n < 600) begin
            tick(1);
            n++;
        end
        check(tag, 144'(n), 144'd513);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ovfl_before;
        int resp_before;

        // reset, init sweep, empty record
        reset_and_init("init_done_latency");
        query(5, 1'b0);

        // accumulation on one index, neighbour untouched
        send_spaced(3, 32'd100);
        send_spaced(3, 32'd40);
        send_spaced(3, 32'd250);
        send_spaced(2, 32'd77);
        check("model_idx3", model[3], {32'd3, 48'd390, 32'd40, 32'd250});
        query(3, 1'b0);
        query(4, 1'b0);

        // clear-on-read
        query(3, 1'b1);
        query(3, 1'b0);
        query(2, 1'b0);

        // random results over a few indices
        for (int i = 0; i < 12; i++) begin
            send_spaced(int'($urandom_range(10, 15)), $urandom);
        end
        for (int i = 10; i <= 15; i++) query(i, 1'b0);

        // large latencies through the full path
        send_spaced(7, 32'hFFFF_FFFF);
        send_spaced(7, 32'hFFFF_FFFF);
        query(7, 1'b0);

        // saturation boundaries on the update function
        sat_in  = '{count: 32'd5, sum: 48'hFFFF_FFFF_0000, min: 32'd10, max: 32'd20};
        sat_lat = 32'hFFFF_FFFF;
        #1;
        check("sat_sum", sat_out, {32'd6, 48'hFFFF_FFFF_FFFF, 32'd10, 32'hFFFF_FFFF});
        sat_in  = '{count: 32'hFFFF_FFFF, sum: 48'd100, min: 32'd50, max: 32'd60};
        sat_lat = 32'd7;
        #1;
        check("sat_count", sat_out, {32'hFFFF_FFFF, 48'd107, 32'd7, 32'd60});
        sat_in  = '{count: 32'd1, sum: 48'hFFFF_0000_0000, min: 32'd5, max: 32'd5};
        sat_lat = 32'hFFFF_FFFF;
        #1;
        check("sum_exact_max", sat_out, {32'd2, 48'hFFFF_FFFF_FFFF, 32'd5, 32'hFFFF_FFFF});
        sat_in  = ENTRY_EMPTY;
        sat_lat = 32'd0;
        #1;
        check("first_sample_zero", sat_out, {32'd1, 48'd0, 32'd0, 32'd0});
        for (int i = 0; i < 8; i++) begin
            sat_in.count = (i % 2 == 1) ? 32'hFFFF_FFFF : $urandom;
            sat_in.sum   = {16'hFFFF - 16'($urandom_range(0, 1)), $urandom};
            sat_in.min   = $urandom;
            sat_in.max   = $urandom;
            sat_lat      = $urandom;
            #1;
            sat_exp = model_upd(sat_in, sat_lat);
            check("upd_rand", sat_out, sat_exp);
        end

        // back-to-back burst of 8 into a 4-deep FIFO: the 7th result is dropped
        tick(10);
        ovfl_before = n_ovfl;
        for (int i = 0; i < 8; i++) begin
            send(20 + i, 32'd1000 + 32'(i), (i != 6));
        end
        tick(30);
        check("ovfl_pulses", 144'(n_ovfl - ovfl_before), 144'd1);
        for (int i = 20; i < 28; i++) query(i, 1'b0);

        // query held during an update burst waits for the drain
        tick(10);
        send(9, 32'd500, 1'b1);
        qry_req   = 1'b1;
        qry_index = 9'd9;
        qry_clear = 1'b0;
        check("ready_low_burst0", 144'(qry_ready), 144'd0);
        send(9, 32'd600, 1'b1);
        check("ready_low_burst1", 144'(qry_ready), 144'd0);
        send(9, 32'd700, 1'b1);
        check("ready_low_burst2", 144'(qry_ready), 144'd0);
        query(9, 1'b0);

        // reset during an update and during a query: nothing comes out
        tick(5);
        resp_before = n_resp;
        send(30, 32'd1234, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(600);
        qry_req   = 1'b1;
        qry_index = 9'd30;
        qry_clear = 1'b0;
        tick(1);
        qry_req = 1'b0;
        rst     = 1'b1;
        tick(1);
        reset_and_init("init_done_after_reset");
        check("no_resp_across_reset", 144'(n_resp - resp_before), 144'd0);
        query(30, 1'b0);
        query(9, 1'b0);

        tick(5);
        check("scoreboard_drain", 144'(exp_q.size()), 144'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/latency_stats.md
Name: latency_stats

Overview:
- Downstream consumer of the latency measurement core's result stream (latency_valid / 48-bit latency_data).
- Keeps a per-index statistics record in one on-chip RAM table: sample count, latency sum, minimum and maximum.
- Software reads each record by index through a request/acknowledge query port, with optional clear-on-read.
- Sits between the measurement core and the control-register block that exposes the statistics.

Parameters:
- INDEX_WIDTH, 9, index width; must match the producer. Table holds NUM_ENTRIES = 1<<INDEX_WIDTH records.
- FIFO_DEPTH, 4, depth of the input result buffer (power of two, 2..16).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- latency_valid  in  1  one-cycle result strobe; there is no ready signal
- latency_data  in  48  [47:32] = {reserved, index}, [31:0] = latency in cycles
- init_done  out  1  high once the table clear sweep has finished
- qry_req  in  1  query request; held until accepted
- qry_ready  out  1  query accepted in any cycle where qry_req && qry_ready
- qry_index  in  INDEX_WIDTH  record to read; sampled on accept
- qry_clear  in  1  re-initialise the record after reading it; sampled on accept
- qry_valid  out  1  one-cycle response strobe
- qry_count  out  32  sample count
- qry_sum  out  48  latency sum
- qry_min  out  32  minimum latency
- qry_max  out  32  maximum latency
- err_fifo_ovfl  out  1  one-cycle pulse when a result is dropped

Behaviour:
- Reset values: all outputs 0. State = ST_INIT, sweep address = 0, FIFO empty.
- Empty record: count=0, sum=0, min=32'hFFFFFFFF, max=0.
- Reserved bits [47:32+INDEX_WIDTH] of latency_data are ignored.
- Input FIFO:
  - A result is pushed whenever latency_valid=1, including while in ST_INIT.
  - If the FIFO is full, the result is dropped and err_fifo_ovfl pulses in the next cycle.
  - A push and a pop in the same cycle are both legal at full and at empty.
- State machine:
  - ST_INIT: writes the empty record to the current address each cycle, address +1. After the write to NUM_ENTRIES-1 → ST_IDLE and init_done=1 on the following cycle; init_done stays high until reset.
  - ST_IDLE:
    - FIFO non-empty → pop, latch {index, latency}, present index as RAM read address → ST_UPD_RD.
    - Else if qry_req → accept, latch index/clear → ST_QRY_RD.
    - Updates always have priority. qry_ready = (state==ST_IDLE) && FIFO empty.
  - ST_UPD_RD: RAM read latency is 1 cycle → ST_UPD_WR.
  - ST_UPD_WR: write the updated record → ST_IDLE.
    - count = saturating +1, holds at 32'hFFFFFFFF.
    - sum = saturating add, holds at 48'hFFFF_FFFF_FFFF.
    - min = smaller of stored min and sample.
    - max = larger of stored max and sample.
    - All comparisons unsigned.
  - ST_QRY_RD: → ST_QRY_OUT.
  - ST_QRY_OUT: drive qry_* with the RAM data and qry_valid=1 for one cycle.
    - If clear was latched, write the empty record to that index in the same cycle.
    - → ST_IDLE.
- Throughput and latency:
  - An update takes 3 cycles from pop to RAM write.
  - qry_valid is asserted 3 cycles after the accept cycle.
  - qry_* outputs hold their values until the next response.
  - The producer emits at most one result per 6 cycles, so FIFO overflow and query starvation are impossible in normal operation. Overflow is a debug indication only.
- Hazards: one RAM operation is in flight at a time, so no forwarding is required. Two consecutive results for the same index both take effect.
- Reset asserted mid-operation: the FIFO contents and any in-flight update or query are discarded, no qry_valid is issued, and the sweep restarts from address 0.

Decomposition:
- Add latency_stats_pkg holding:
  - stats_entry_t: packed {count[31:0], sum[47:0], min[31:0], max[31:0]}, 144 bits.
  - result_t: matches the producer's 48-bit layout.
  - state_t.
  - Constant ENTRY_EMPTY.
- Reuse the existing ram_fifo for the input buffer and ram_sdp for the table.
- Natural sub-module: latency_stats_update, the combinational saturating accumulate/min/max function of (stats_entry_t, latency).

Test Plan:
- After reset: init_done rises 2^9 + 1 cycles after rst deasserts. Query index 5 → count=0, sum=0, min=FFFFFFFF, max=0.
- Results idx 3 with latencies 100, 40, 250, spaced 6 cycles apart; then query idx 3 → count=3, sum=390, min=40, max=250. Query idx 4 → empty record.
- Query idx 3 with qry_clear=1 → same values as above. A second query → empty record. Idx 2 is unaffected.
- Preload idx 7 sum = 48'hFFFF_FFFF_0000 via results; add latency FFFFFFFF → sum saturates at 48'hFFFF_FFFF_FFFF and count increments normally.
- Back-to-back latency_valid for 8 cycles with FIFO_DEPTH=4 → exactly the overflowing results are dropped, each with one err_fifo_ovfl pulse; accepted results are all reflected in queries.
- qry_req held during an update burst → qry_ready stays low until the FIFO drains; the query then returns the post-update values. Assert rst mid-update → no qry_valid, and init restarts from address 0.
